// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for common-anode 7-segment digits.
// Blanks between digits and double-buffers loads so a frame never mixes old and new values.
//
// state | meaning
// IDLE  | display dark; a pending load commits on the next edge
// BLANK | all anodes off for BLANK_CYCLES ahead of digit digit_idx
// SHOW  | anode digit_idx low, segments follow the shared decoder
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_WIDTH  = 4,
    parameter int SEG_WIDTH    = 7,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] load_data,
    output logic [DIGIT_WIDTH-1:0]            dec_in,
    input  logic [SEG_WIDTH-1:0]              dec_out,
    output logic [SEG_WIDTH-1:0]              seg_out,
    output logic [NUM_DIGITS-1:0]             an_out,
    output logic                              frame_tick
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(NUM_DIGITS - 1);

    logic [1:0]                                state, state_n;
    logic [IW-1:0]                             digit_idx, idx_n;
    logic [CW-1:0]                             cnt, cnt_n;
    logic [NUM_DIGITS-1:0][DIGIT_WIDTH-1:0]    disp_reg, shadow;
    logic                                      pending;
    logic                                      take;
    logic                                      frame_start;
    logic                                      wrap_commit;
    logic [NUM_DIGITS-1:0]                     an_n;

    assign load_ready = ~pending;
    assign take       = load_valid & ~pending;
    assign dec_in     = disp_reg[digit_idx];

    always_comb begin
        state_n     = state;
        idx_n       = digit_idx;
        cnt_n       = cnt;
        frame_start = 1'b0;
        wrap_commit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_n     = ST_BLANK;
                    idx_n       = '0;
                    cnt_n       = '0;
                    frame_start = 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    if (digit_idx == DIGIT_LAST) begin
                        idx_n       = '0;
                        frame_start = 1'b1;
                        wrap_commit = 1'b1;
                    end else begin
                        idx_n = digit_idx + IW'(1);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase

        // Going dark overrides whatever scan step would have happened this edge.
        if (!enable && state != ST_IDLE) begin
            state_n     = ST_IDLE;
            idx_n       = '0;
            cnt_n       = '0;
            frame_start = 1'b0;
            wrap_commit = 1'b0;
        end
    end

    always_comb begin
        an_n = '1;
        if (state_n == ST_SHOW) begin
            an_n[idx_n] = 1'b0;
        end
    end

    // Outputs are registered against the next state so anode and segments change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            digit_idx  <= '0;
            cnt        <= '0;
            disp_reg   <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            seg_out    <= '1;
            an_out     <= '1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            digit_idx  <= idx_n;
            cnt        <= cnt_n;
            frame_tick <= frame_start;
            an_out     <= an_n;
            seg_out    <= (state_n == ST_SHOW) ? dec_out : '1;
            if (take) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end else if (pending && (state == ST_IDLE || wrap_commit)) begin
                disp_reg <= shadow;
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: IDLE handshake vector table plus per-cycle scan scoreboard,
// with directed decoder-override and asynchronous-reset sequences.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  dec_in;
    logic [6:0]  dec_out;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    logic        ovr;
    logic [6:0]  ovr_val;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .DIGIT_WIDTH (4),
        .SEG_WIDTH   (7),
        .SHOW_CYCLES (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .dec_in    (dec_in),
        .dec_out   (dec_out),
        .seg_out   (seg_out),
        .an_out    (an_out),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb dec_out = ovr ? ovr_val : seg7(dec_in);

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic [3:0] dec;
        logic       ft;
        logic       rdy;
    } rec_t;

    typedef struct {
        logic        en;
        logic        lv;
        logic [15:0] data;
        logic        rdy;
        logic [3:0]  dec;
    } idle_vec_t;

    rec_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_rec   = 0;
    int   cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Expected per-cycle picture of one frame: 2 dark cycles then 4 lit cycles per digit.
    task automatic push_frame(input logic [15:0] val, input int busy_from, input int ncyc);
        rec_t r;
        for (int c = 0; c < ncyc; c++) begin
            int d;
            int p;
            d     = c / 6;
            p     = c % 6;
            r.dec = val[4*d +: 4];
            r.an  = (p < 2) ? 4'hF : ~(4'b0001 << d);
            r.seg = (p < 2) ? 7'h7F : seg7(r.dec);
            r.ft  = (c == 0);
            r.rdy = (c < busy_from);
            sb.push_back(r);
        end
    endtask

    task automatic push_dark(input logic [3:0] dec, input logic rdy);
        rec_t r;
        r.an  = 4'hF;
        r.seg = 7'h7F;
        r.dec = dec;
        r.ft  = 1'b0;
        r.rdy = rdy;
        sb.push_back(r);
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            rec_t e;
            rec_t a;
            e = sb.pop_front();
            a = '{an: an_out, seg: seg_out, dec: dec_in, ft: frame_tick, rdy: load_ready};
            check($sformatf("scan%0d{an,seg,dec,ft,rdy}", n_rec), 32'(a), 32'(e));
            n_rec++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_vec_t tbl[6];
        tbl[0] = '{en: 1'b0, lv: 1'b1, data: 16'hABCD, rdy: 1'b0, dec: 4'h0};
        tbl[1] = '{en: 1'b0, lv: 1'b1, data: 16'h9999, rdy: 1'b1, dec: 4'hD};
        tbl[2] = '{en: 1'b0, lv: 1'b0, data: 16'h0000, rdy: 1'b1, dec: 4'hD};
        tbl[3] = '{en: 1'b0, lv: 1'b1, data: 16'h3210, rdy: 1'b0, dec: 4'hD};
        tbl[4] = '{en: 1'b0, lv: 1'b0, data: 16'h0000, rdy: 1'b1, dec: 4'h0};
        tbl[5] = '{en: 1'b0, lv: 1'b0, data: 16'h0000, rdy: 1'b1, dec: 4'h0};

        rst_n      = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0;
        ovr        = 1'b0;
        ovr_val    = 7'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_an", 32'(an_out), 32'h0F);
        check("reset_seg", 32'(seg_out), 32'h7F);
        check("reset_dec_in", 32'(dec_in), 32'h0);
        check("reset_ready", 32'(load_ready), 32'h1);
        check("reset_frame_tick", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            enable     = tbl[i].en;
            load_valid = tbl[i].lv;
            load_data  = tbl[i].data;
            @(posedge clk);
            #1;
            push_dark(tbl[i].dec, tbl[i].rdy);
        end

        enable = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
        push_frame(16'h3210, 9, 24);
        push_frame(16'h7654, 1, 24);
        push_frame(16'hC8A5, 24, 24);
        push_frame(16'hC8A5, 24, 16);
        for (int i = 0; i < 3; i++) push_dark(4'h5, 1'b1);
        push_frame(16'hC8A5, 24, 24);

        goto(8);
        load_valid = 1'b1;
        load_data  = 16'h7654;
        goto(9);
        load_data  = 16'hC8A5;
        goto(25);
        load_valid = 1'b0;
        goto(87);
        enable = 1'b0;
        goto(90);
        enable = 1'b1;

        goto(117);
        check("ovr_pre_an", 32'(an_out), 32'hE);
        check("ovr_pre_seg", 32'(seg_out), 32'(seg7(4'h5)));
        ovr     = 1'b1;
        ovr_val = 7'h24;
        goto(118);
        check("ovr_seg_next_cycle", 32'(seg_out), 32'h24);
        ovr = 1'b0;
        goto(119);
        check("ovr_release_seg", 32'(seg_out), 32'(seg7(4'h5)));
        load_valid = 1'b1;
        load_data  = 16'h1111;
        goto(120);
        load_valid = 1'b0;
        check("pre_reset_ready", 32'(load_ready), 32'h0);
        check("pre_reset_an", 32'(an_out), 32'hE);
        rst_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an_out), 32'h0F);
        check("async_reset_seg", 32'(seg_out), 32'h7F);
        check("async_reset_ready", 32'(load_ready), 32'h1);
        check("async_reset_dec_in", 32'(dec_in), 32'h0);
        check("async_reset_frame_tick", 32'(frame_tick), 32'h0);
        #20;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
